// File: rtl/rapid_pkg.sv
// Shared decode types, RV32 opcode constants and ALU-op helpers for the decode stage.
package rapid_pkg;

  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  typedef enum logic [4:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB,
    AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu
  } alu_op_e;

  typedef enum logic [2:0] {ClsNone, ClsR, ClsI, ClsS, ClsB, ClsU, ClsJ} instr_class_e;

  typedef struct packed {
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [31:0]  imm;
    logic [2:0]   funct3;
    alu_op_e      alu_op;
    instr_class_e instr_class;
    logic         rd_we;
  } decoded_instr_t;

  // alt selects SUB/SRA over ADD/SRL
  function automatic alu_op_e alu_base_op(logic [2:0] funct3, logic alt);
    case (funct3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  function automatic alu_op_e alu_mul_op(logic [2:0] funct3);
    case (funct3)
      3'b000:  return AluMul;
      3'b001:  return AluMulh;
      3'b010:  return AluMulhsu;
      3'b011:  return AluMulhu;
      3'b100:  return AluDiv;
      3'b101:  return AluDivu;
      3'b110:  return AluRem;
      default: return AluRemu;
    endcase
  endfunction

endpackage

// File: rtl/cpu_idecode_unit_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface cpu_idecode_unit_if;
  logic                           i_valid;
  logic [31:0]                    i_pc;
  logic [31:0]                    i_instruction;
  logic                           o_ready;
  logic                           i_flush;
  logic                           o_valid;
  logic                           i_ready;
  logic [31:0]                    o_pc;
  rapid_pkg::decoded_instr_t      o_decoded;
  logic                           o_illegal;

  modport master (
    output i_valid, i_pc, i_instruction, i_flush, i_ready,
    input  o_ready, o_valid, o_pc, o_decoded, o_illegal
  );

  modport slave (
    input  i_valid, i_pc, i_instruction, i_flush, i_ready,
    output o_ready, o_valid, o_pc, o_decoded, o_illegal
  );
endinterface

// File: rtl/cpu_idecode_logic.sv
// Combinational RV32I decoder; RV32M decode enabled by CPU_IDECODE_RV32M_EN.
module cpu_idecode_logic
  import rapid_pkg::*;
(
  input  logic [31:0]    instr_i,
  output decoded_instr_t dec_o,
  output logic           illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        writes_rd;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                  1'b0};

  always_comb begin
    dec_o        = '0;
    dec_o.rd     = instr_i[11:7];
    dec_o.rs1    = instr_i[19:15];
    dec_o.rs2    = instr_i[24:20];
    dec_o.funct3 = funct3;
    writes_rd    = 1'b0;
    illegal_o    = 1'b0;
    case (opcode)
      OpcLui: begin
        dec_o.imm = imm_u; dec_o.alu_op = AluPassB; dec_o.instr_class = ClsU; writes_rd = 1'b1;
      end
      OpcAuipc: begin
        dec_o.imm = imm_u; dec_o.instr_class = ClsU; writes_rd = 1'b1;
      end
      OpcJal: begin
        dec_o.imm = imm_j; dec_o.instr_class = ClsJ; writes_rd = 1'b1;
      end
      OpcJalr: begin
        dec_o.imm = imm_i; dec_o.instr_class = ClsI; writes_rd = 1'b1;
        illegal_o = (funct3 != 3'b000);
      end
      OpcBranch: begin
        dec_o.imm = imm_b; dec_o.alu_op = AluSub; dec_o.instr_class = ClsB;
        illegal_o = (funct3 inside {3'b010, 3'b011});
      end
      OpcLoad: begin
        dec_o.imm = imm_i; dec_o.instr_class = ClsI; writes_rd = 1'b1;
        illegal_o = (funct3 inside {3'b011, 3'b110, 3'b111});
      end
      OpcStore: begin
        dec_o.imm = imm_s; dec_o.instr_class = ClsS;
        illegal_o = funct3[2] | (funct3 == 3'b011);
      end
      OpcOpImm: begin
        dec_o.imm = imm_i; dec_o.instr_class = ClsI; writes_rd = 1'b1;
        dec_o.alu_op = alu_base_op(funct3, (funct3 == 3'b101) & funct7[5]);
        // Shift-immediates reuse imm[11:5] as a funct7 that must be well-formed
        illegal_o = ((funct3 == 3'b001) && (funct7 != 7'b0))
                 || ((funct3 == 3'b101) && (funct7 != 7'b0) && (funct7 != 7'b0100000));
      end
      OpcOp: begin
        dec_o.instr_class = ClsR; writes_rd = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_o.alu_op = alu_base_op(funct3, 1'b0);
        end else if (funct7 == 7'b0100000) begin
          dec_o.alu_op = alu_base_op(funct3, 1'b1);
          illegal_o = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else if (funct7 == 7'b0000001) begin
`ifdef CPU_IDECODE_RV32M_EN
          dec_o.alu_op = alu_mul_op(funct3);
`else
          illegal_o = 1'b1;
`endif
        end else begin
          illegal_o = 1'b1;
        end
      end
      OpcMiscMem: begin
        dec_o.imm = imm_i; dec_o.instr_class = ClsI;
      end
      OpcSystem: begin
        dec_o.imm = imm_i; dec_o.instr_class = ClsI; writes_rd = 1'b1;
        illegal_o = (funct3 == 3'b100);
      end
      default: illegal_o = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) illegal_o = 1'b1;
    dec_o.rd_we = writes_rd & ~illegal_o & (dec_o.rd != 5'd0);
  end

endmodule

// File: rtl/cpu_idecode_unit.sv
// Decode stage: combinational decode into a two-entry skid buffer (EMPTY/FULL/SKID).
// CPU_IDECODE_RV32M_EN enables RV32M decode in cpu_idecode_logic.
module cpu_idecode_unit
  import rapid_pkg::*;
(
  input logic               i_clk,
  input logic               i_reset_n,
  cpu_idecode_unit_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  typedef struct packed {
    logic [31:0]    pc;
    decoded_instr_t dec;
    logic           illegal;
  } entry_t;

  state_e         state_q, state_d;
  entry_t         main_q, main_d, skid_q, skid_d, in_entry;
  logic           ready_q, ready_d;
  logic           valid;
  logic           in_xfer, out_xfer;
  decoded_instr_t in_dec;
  logic           in_illegal;

  cpu_idecode_logic u_logic (
    .instr_i   (bus.i_instruction),
    .dec_o     (in_dec),
    .illegal_o (in_illegal)
  );

  assign in_entry = '{pc: bus.i_pc, dec: in_dec, illegal: in_illegal};
  assign valid    = (state_q == StFull) || (state_q == StSkid);
  assign in_xfer  = bus.i_valid & ready_q;
  assign out_xfer = valid & bus.i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d = StFull;
          main_d  = in_entry;
        end
      end
      StFull: begin
        if (in_xfer && out_xfer) begin
          main_d = in_entry;
        end else if (in_xfer) begin
          state_d = StSkid;
          skid_d  = in_entry;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (out_xfer) begin
          state_d = StFull;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Redirect wins over any same-cycle transfer
    if (bus.i_flush) state_d = StEmpty;
    ready_d = (state_d != StSkid);
  end

  always_comb begin
    bus.o_valid   = valid;
    bus.o_ready   = ready_q;
    bus.o_pc      = main_q.pc;
    bus.o_decoded = main_q.dec;
    bus.o_illegal = main_q.illegal;
  end

endmodule
